tree_vote_sequencer: RTL



---
 rtl/tree_vote_pkg.sv | 18 +
 rtl/tree_vote_acc.sv | 57 +++++
 rtl/tree_vote_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tree_vote_pkg.sv
// Shared types and width helpers for the tree vote sequencer.
package tree_vote_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int vote_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tree_vote_acc.sv
// Saturating vote counter with registered majority decision.
module tree_vote_acc
  import tree_vote_pkg::*;
#(
  parameter int NUM_TREES = 8,
  parameter int VW        = vote_w(NUM_TREES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          add_en_i,
  input  logic          bit_i,
  output logic [VW-1:0] votes_o,
  output logic          class_o
);

  localparam logic [VW-1:0] MAX_VOTES = VW'(NUM_TREES);
  localparam logic [VW-1:0] HALF      = VW'(NUM_TREES / 2);

  logic [VW-1:0] votes_q, votes_d;
  logic          class_q, class_d;

  // Next vote count and majority; a tie is not a majority.
  always_comb begin
    votes_d = votes_q;
    class_d = class_q;
    if (clr_i) begin
      votes_d = {VW{1'b0}};
      class_d = 1'b0;
    end else if (add_en_i) begin
      if (bit_i && (votes_q != MAX_VOTES)) begin
        votes_d = votes_q + VW'(1);
      end else begin
        votes_d = votes_q;
      end
      class_d = (votes_d > HALF);
    end else begin
      votes_d = votes_q;
      class_d = class_q;
    end
  end

  // Count and decision registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      votes_q <= {VW{1'b0}};
      class_q <= 1'b0;
    end else begin
      votes_q <= votes_d;
      class_q <= class_d;
    end
  end

  assign votes_o = votes_q;
  assign class_o = class_q;

endmodule

// File: rtl/tree_vote_sequencer.sv
// Sequences one feature vector through a shared tree bank and emits a majority vote.
// Optional feature: define TREE_VOTE_EARLY_EXIT_EN to stop once the outcome is decided.
module tree_vote_sequencer
  import tree_vote_pkg::*;
#(
  parameter int NUM_TREES = 8,
  parameter int FEAT_W    = 51
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_W-1:0]             in_feat,
  output logic [FEAT_W-1:0]             tree_feat,
  output logic [sel_w(NUM_TREES)-1:0]   tree_sel,
  input  logic                          tree_bit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_class,
  output logic [vote_w(NUM_TREES)-1:0]  out_votes
);

  localparam int SW = sel_w(NUM_TREES);
  localparam int VW = vote_w(NUM_TREES);
  localparam logic [SW-1:0] LAST_SEL = SW'(NUM_TREES - 1);

  state_t            state_q;
  logic [FEAT_W-1:0] feat_q;
  logic [SW-1:0]     sel_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept_s;
  logic              eval_s;
  logic              exit_s;
  logic [VW-1:0]     votes_s;
  logic              class_s;

  assign accept_s = (state_q == IDLE) && in_valid && in_ready_q;
  assign eval_s   = (state_q == EVAL);

`ifdef TREE_VOTE_EARLY_EXIT_EN
  localparam logic [VW-1:0] HALF = VW'(NUM_TREES / 2);
  logic [VW-1:0] ones_s, seen_s, zeros_s;

  // Leave EVAL once either ones or zeros form a strict majority.
  always_comb begin
    ones_s  = votes_s + VW'(tree_bit);
    seen_s  = VW'(sel_q) + VW'(1);
    zeros_s = seen_s - ones_s;
    if ((sel_q == LAST_SEL) || (ones_s > HALF) || (zeros_s > HALF)) begin
      exit_s = 1'b1;
    end else begin
      exit_s = 1'b0;
    end
  end
`else
  assign exit_s = (sel_q == LAST_SEL);
`endif

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      feat_q      <= {FEAT_W{1'b0}};
      sel_q       <= {SW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            feat_q     <= in_feat;
            sel_q      <= {SW{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= EVAL;
          end
        end
        EVAL: begin
          if (exit_s) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sel_q <= sel_q + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  tree_vote_acc #(
    .NUM_TREES(NUM_TREES),
    .VW       (VW)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept_s),
    .add_en_i(eval_s),
    .bit_i   (tree_bit),
    .votes_o (votes_s),
    .class_o (class_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign tree_feat = feat_q;
  assign tree_sel  = sel_q;
  assign out_votes = votes_s;
  assign out_class = class_s;

endmodule
